// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, program length, fetch FSM states and instruction
// field positions for the fetch unit and its buffer.
package cpu_pkg;

  localparam int unsigned PC_W       = 8;
  localparam int unsigned INSTR_W    = 18;
  localparam int unsigned PROG_LEN   = 8;

  // Fetch buffer geometry; count is one bit wider than the pointers.
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  // Instruction layout {op[1:0], a[7:0], b[7:0]}.
  localparam int unsigned OP_MSB = 17;
  localparam int unsigned OP_LSB = 16;
  localparam int unsigned A_MSB  = 15;
  localparam int unsigned A_LSB  = 8;
  localparam int unsigned B_MSB  = 7;
  localparam int unsigned B_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Pack instruction fields into the default-width word.
  function automatic logic [INSTR_W-1:0] make_instr(input logic [1:0] op,
                                                    input logic [7:0] a,
                                                    input logic [7:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 4-entry buffer with flush and a registered head output.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush_i        drop all entries (wins over push/pop)
//   push_i         write push_data_i (ignored when full)
//   push_data_i    entry to write
//   pop_i          retire head entry (ignored when empty)
//   count_o        number of entries held (0..4)
//   valid_o        head_o holds an entry
//   head_o         oldest entry, zero when empty
module fetch_fifo #(
  parameter int unsigned W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [2:0]   count_o,
  output logic         valid_o,
  output logic [W-1:0] head_o
);
  import cpu_pkg::*;

  logic [W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               vld_q, vld_d;
  logic [W-1:0]       head_q, head_d;
  logic               push_en, pop_en;

  // Pointer/count update and look-ahead of the next head entry.
  always_comb begin
    push_en  = push_i && (count_q != CNT_W'(FIFO_DEPTH)) && !flush_i;
    pop_en   = pop_i && (count_q != '0) && !flush_i;
    wr_ptr_d = push_en ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = CNT_W'(count_q + CNT_W'(push_en) - CNT_W'(pop_en));
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    vld_d = (count_d != '0);
    // The next head may be the entry being written this very edge.
    if (count_d == '0) begin
      head_d = '0;
    end else if (push_en && (rd_ptr_d == wr_ptr_q)) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = vld_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch from a 1-cycle registered
// instruction memory into a 4-entry buffer feeding a valid/ready decode stage.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start_i         begin fetching at pc 0 (IDLE only)
//   pc_o            instruction-memory address
//   instr_i         memory data for the previous cycle's pc_o
//   redirect_i      flush and restart at redirect_pc_i (RUN/HALT only)
//   redirect_pc_i   redirect target; >= PROG_LEN halts instead
//   valid_o         instr_o/pc_out_o hold a fetched instruction
//   ready_i         downstream accepts when valid_o && ready_i
//   instr_o         fetched instruction
//   pc_out_o        pc of instr_o
//   halted_o        HALT with buffer and pipe empty (combinational)
module fetch_unit #(
  parameter int unsigned PC_W     = cpu_pkg::PC_W,
  parameter int unsigned INSTR_W  = cpu_pkg::INSTR_W,
  parameter int unsigned PROG_LEN = cpu_pkg::PROG_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic [PC_W-1:0]    pc_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_out_o,
  output logic               halted_o
);
  import cpu_pkg::*;

  localparam int unsigned       ENT_W   = PC_W + INSTR_W;
  localparam logic [PC_W-1:0]   LAST_PC = PC_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0]  CREDITS = CNT_W'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              s1_vld_q, s1_vld_d;   // pc_o is a live issue this cycle
  logic              s2_vld_q, s2_vld_d;   // instr_i is live this cycle
  logic [PC_W-1:0]   s2_pc_q, s2_pc_d;

  logic              fifo_flush, fifo_push, fifo_pop, fifo_vld;
  logic [ENT_W-1:0]  fifo_head;
  logic [2:0]        fifo_count;
  logic [CNT_W-1:0]  occupied;
  logic              credit_ok;
  logic [PC_W-1:0]   next_pc;
  logic              redir_ok;

  // Next state, pc issue and in-flight pipe.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    s1_vld_d   = 1'b0;
    s2_vld_d   = s1_vld_q;
    s2_pc_d    = pc_q;
    fifo_flush = 1'b0;

    // Every issued pc owns a buffer slot until it is popped.
    occupied  = CNT_W'(fifo_count + CNT_W'(s1_vld_q) + CNT_W'(s2_vld_q));
    credit_ok = (occupied < CREDITS);
    next_pc   = PC_W'(pc_q + 1'b1);
    redir_ok  = (32'(redirect_pc_i) < PROG_LEN);

    if ((state_q != IDLE) && redirect_i) begin
      fifo_flush = 1'b1;
      s2_vld_d   = 1'b0;
      if (redir_ok) begin
        pc_d     = redirect_pc_i;
        s1_vld_d = 1'b1;
        state_d  = (redirect_pc_i == LAST_PC) ? HALT : RUN;
      end else begin
        state_d  = HALT;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            pc_d     = '0;
            s1_vld_d = 1'b1;
            state_d  = (LAST_PC == '0) ? HALT : RUN;
          end
        end
        RUN: begin
          if (credit_ok) begin
            pc_d     = next_pc;
            s1_vld_d = 1'b1;
            if (next_pc == LAST_PC) begin
              state_d = HALT;
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and pipe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_pc_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s2_pc_q  <= s2_pc_d;
    end
  end

  assign fifo_push = s2_vld_q;
  assign fifo_pop  = fifo_vld && ready_i;

  fetch_fifo #(
    .W (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i ({s2_pc_q, instr_i}),
    .pop_i       (fifo_pop),
    .count_o     (fifo_count),
    .valid_o     (fifo_vld),
    .head_o      (fifo_head)
  );

  assign pc_o     = pc_q;
  assign valid_o  = fifo_vld;
  assign pc_out_o = fifo_head[ENT_W-1 -: PC_W];
  assign instr_o  = fifo_head[INSTR_W-1:0];
  assign halted_o = (state_q == HALT) && (fifo_count == '0) && !s1_vld_q && !s2_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus keeps a queue of
// the pcs the decode side should still receive; a negedge monitor pops it on
// every transfer and checks pc and instruction against the memory image.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start_i = 1'b0;
  logic                redirect_i = 1'b0;
  logic [PC_W-1:0]     redirect_pc_i = '0;
  logic                ready_i = 1'b0;
  logic [PC_W-1:0]     pc_o;
  logic [INSTR_W-1:0]  instr_i;
  logic                valid_o;
  logic [INSTR_W-1:0]  instr_o;
  logic [PC_W-1:0]     pc_out_o;
  logic                halted_o;

  logic [INSTR_W-1:0]  im [256];
  int unsigned         exp_q [$];
  int                  vectors = 0;
  int                  miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .pc_o          (pc_o),
    .instr_i       (instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_out_o      (pc_out_o),
    .halted_o      (halted_o)
  );

  // Registered instruction memory.
  always @(posedge clk) instr_i <= im[pc_o];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every transfer with the scoreboard, and check that a
  // stalled beat is still presented unchanged one cycle later.
  logic               hold_chk = 1'b0;
  logic [PC_W-1:0]    hold_pc;
  logic [INSTR_W-1:0] hold_instr;
  always @(negedge clk) begin
    int unsigned e;
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check("stall_valid", int'(valid_o), 1);
        check("stall_pc", int'(pc_out_o), int'(hold_pc));
        check("stall_instr", int'(instr_o), int'(hold_instr));
      end
      hold_chk   = valid_o && !ready_i && !redirect_i;
      hold_pc    = pc_out_o;
      hold_instr = instr_o;
      if (valid_o && ready_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_pc", int'(pc_out_o), -1);
        end else begin
          e = exp_q.pop_front();
          check("beat_pc", int'(pc_out_o), int'(e));
          check("beat_instr", int'(instr_o), int'(im[e[7:0]]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart(input int p);
    exp_q.delete();
    for (int k = p; k < int'(PROG_LEN); k++) exp_q.push_back(k);
  endtask

  task automatic do_redirect(input int p);
    redirect_i    = 1'b1;
    redirect_pc_i = PC_W'(p);
    cyc();
    redirect_i    = 1'b0;
    model_restart(p);
  endtask

  task automatic wait_halted(input int budget, input string name);
    for (int i = 0; i < budget && !halted_o; i++) cyc();
    check({name, "_halted"}, int'(halted_o), 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) im[i] = '0;
    im[0] = make_instr(2'd0, 8'd100, 8'd50);
    im[1] = make_instr(2'd1, 8'd150, 8'd120);
    im[2] = make_instr(2'd2, 8'd2,   8'd20);
    im[3] = make_instr(2'd3, 8'd100, 8'd25);
    im[4] = make_instr(2'd3, 8'd100, 8'd30);
    im[5] = make_instr(2'd2, 8'd5,   8'd50);
    im[6] = make_instr(2'd0, 8'd20,  8'd50);
    im[7] = make_instr(2'd1, 8'd90,  8'd45);

    // Reset values, then idle until start.
    #12;
    check("rst_valid", int'(valid_o), 0);
    check("rst_pc", int'(pc_o), 0);
    check("rst_halted", int'(halted_o), 0);
    check("rst_instr", int'(instr_o), 0);
    check("rst_pc_out", int'(pc_out_o), 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    check("idle_valid", int'(valid_o), 0);
    check("idle_halted", int'(halted_o), 0);

    // Straight-line run with ready held high.
    ready_i = 1'b1;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    model_restart(0);
    check("lat_pc0", int'(pc_o), 0);
    check("lat_valid_n0", int'(valid_o), 0);
    cyc();
    check("lat_valid_n1", int'(valid_o), 0);
    cyc();
    check("lat_valid_n2", int'(valid_o), 1);
    check("lat_pc_out_n2", int'(pc_out_o), 0);
    for (int k = 1; k < 8; k++) begin
      cyc();
      check("gapless_valid", int'(valid_o), 1);
      check("gapless_pc", int'(pc_out_o), k);
    end
    cyc();
    check("run_end_valid", int'(valid_o), 0);
    wait_halted(1, "run");

    // Backpressure after beat 2: at most four pcs past it may be issued.
    do_redirect(0);
    for (int i = 0; i < 20 && !(valid_o && pc_out_o == 8'd2); i++) cyc();
    check("bp_saw_pc2", int'(valid_o && pc_out_o == 8'd2), 1);
    cyc();
    ready_i = 1'b0;
    begin
      logic [PC_W-1:0] mid_pc;
      mid_pc = '0;
      for (int i = 0; i < 6; i++) begin
        cyc();
        if (i == 2) mid_pc = pc_o;
      end
      check("bp_freeze_pc", int'(pc_o), 2 + 4);
      check("bp_frozen", int'(pc_o), int'(mid_pc));
      check("bp_head_pc", int'(pc_out_o), 3);
    end
    ready_i = 1'b1;
    wait_halted(20, "bp");

    // Redirect to 5 with three entries buffered.
    ready_i = 1'b0;
    do_redirect(0);
    repeat (4) cyc();
    check("rd_pre_head", int'(pc_out_o), 0);
    do_redirect(5);
    ready_i = 1'b1;
    check("rd_valid_e0", int'(valid_o), 0);
    cyc();
    check("rd_valid_e1", int'(valid_o), 0);
    cyc();
    check("rd_valid_e2", int'(valid_o), 1);
    check("rd_pc_e2", int'(pc_out_o), 5);
    check("rd_instr_e2", int'(instr_o), int'(im[5]));
    wait_halted(10, "rd");

    // Out-of-range redirect halts immediately with nothing further.
    do_redirect(0);
    repeat (3) cyc();
    do_redirect(9);
    check("oor_halted", int'(halted_o), 1);
    check("oor_valid", int'(valid_o), 0);
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        cyc();
        if (valid_o) seen++;
      end
      check("oor_no_beats", seen, 0);
    end

    // Asynchronous reset with pc 4 in flight.
    do_redirect(0);
    for (int i = 0; i < 10 && pc_o != 8'd4; i++) cyc();
    check("ar_pc4", int'(pc_o), 4);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", int'(valid_o), 0);
    check("ar_pc", int'(pc_o), 0);
    check("ar_pc_out", int'(pc_out_o), 0);
    check("ar_halted", int'(halted_o), 0);
    exp_q.delete();
    cyc();
    cyc();
    #2;
    rst_n = 1'b1;
    repeat (3) cyc();
    check("ar_idle_valid", int'(valid_o), 0);
    check("ar_idle_pc", int'(pc_o), 0);

    // start and redirect together in IDLE: redirect ignored.
    start_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 8'd5;
    cyc();
    start_i    = 1'b0;
    redirect_i = 1'b0;
    model_restart(0);
    check("sr_pc", int'(pc_o), 0);
    cyc();
    cyc();
    check("sr_valid", int'(valid_o), 1);
    check("sr_pc_out", int'(pc_out_o), 0);
    wait_halted(20, "sr");

    // Random ready and redirects over a fresh program image.
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(PROG_LEN); i++) im[i] = INSTR_W'($urandom);
    cyc();
    #2;
    rst_n   = 1'b1;
    cyc();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    model_restart(0);
    for (int it = 0; it < 800; it++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0 || (halted_o && $urandom_range(0, 3) == 0))
        do_redirect(int'($urandom_range(0, 9)));
      else
        cyc();
    end
    ready_i = 1'b1;
    wait_halted(40, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
